// File: rtl/nmi_arbiter.sv
// Round-robin N-to-1 NMI arbiter; each transaction is locked to one master from grant to completion.
// Latency: request sampled in IDLE in cycle t reaches m_nmi_valid in t+1; one transaction per 2 cycles peak.
// Backpressure: m_nmi_ready stalls hold BUSY; optional stall abort via NMI_ARBITER_TIMEOUT_EN.
module nmi_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WSTRB_WIDTH    = (DATA_WIDTH-1)/8+1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [N_MASTERS-1:0]               s_nmi_valid,
  input  logic [N_MASTERS-1:0]               s_nmi_instr,
  output logic [N_MASTERS-1:0]               s_nmi_ready,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]    s_nmi_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]    s_nmi_wdata,
  input  logic [N_MASTERS*WSTRB_WIDTH-1:0]   s_nmi_wstrb,
  output logic [N_MASTERS*DATA_WIDTH-1:0]    s_nmi_rdata,
  output logic                               m_nmi_valid,
  output logic                               m_nmi_instr,
  input  logic                               m_nmi_ready,
  output logic [ADDR_WIDTH-1:0]              m_nmi_addr,
  output logic [DATA_WIDTH-1:0]              m_nmi_wdata,
  output logic [WSTRB_WIDTH-1:0]             m_nmi_wstrb,
  input  logic [DATA_WIDTH-1:0]              m_nmi_rdata
`ifdef NMI_ARBITER_TIMEOUT_EN
  ,
  output logic                               timeout_err
`endif
);

  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [DATA_WIDTH-1:0] DEAD_PATTERN = {DATA_WIDTH/16{16'hDEAD}};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]          sel;
  logic [GW-1:0]          cand;
  logic [GW-1:0]          pick_idx;
  logic                   pick_vld;
  logic [GW-1:0]          next_ptr;
  logic                   abort;
  logic [DATA_WIDTH-1:0]  rdata_bcast;

  logic [ADDR_WIDTH-1:0]  addr_a  [N_MASTERS];
  logic [DATA_WIDTH-1:0]  wdata_a [N_MASTERS];
  logic [WSTRB_WIDTH-1:0] wstrb_a [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
    assign addr_a[i]  = s_nmi_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = s_nmi_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_a[i] = s_nmi_wstrb[i*WSTRB_WIDTH +: WSTRB_WIDTH];
    assign s_nmi_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata_bcast;
  end

  // Outside BUSY the request fields simply show slice 0.
  assign sel         = (state_q == BUSY) ? grant_q : '0;
  assign m_nmi_addr  = addr_a[sel];
  assign m_nmi_wdata = wdata_a[sel];
  assign m_nmi_wstrb = wstrb_a[sel];
  assign m_nmi_instr = s_nmi_instr[sel];
  assign rdata_bcast = abort ? DEAD_PATTERN : m_nmi_rdata;
  assign next_ptr    = (grant_q == GW'(N_MASTERS-1)) ? '0 : grant_q + 1'b1;

  // Descending scan so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N_MASTERS-1; k >= 0; k--) begin
      cand = GW'((int'(rr_ptr_q) + k) % N_MASTERS);
      if (s_nmi_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef NMI_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] stall_q;

  assign abort       = (state_q == BUSY) && (stall_q == CW'(TIMEOUT_CYCLES));
  assign timeout_err = abort;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (state_q == IDLE) begin
      stall_q <= '0;
    end else if (!m_nmi_ready && !abort) begin
      stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    m_nmi_valid = 1'b0;
    s_nmi_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        m_nmi_valid = s_nmi_valid[grant_q] & ~abort;
        if (abort || (m_nmi_valid && m_nmi_ready)) begin
          s_nmi_ready[grant_q] = 1'b1;
          rr_ptr_d             = next_ptr;
          state_d              = IDLE;
        end else if (!s_nmi_valid[grant_q]) begin
          // Master withdrew mid-transaction: drop it without moving priority.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Randomized and directed bench for nmi_arbiter against a transaction-level round-robin model.
module tb_nmi_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic [N-1:0]      v, ins;
  logic [AW-1:0]     a_addr  [N];
  logic [DW-1:0]     a_wdata [N];
  logic [SW-1:0]     a_wstrb [N];
  logic              mr;
  logic [DW-1:0]     mrd;

  logic [N*AW-1:0]   s_nmi_addr;
  logic [N*DW-1:0]   s_nmi_wdata;
  logic [N*SW-1:0]   s_nmi_wstrb;
  logic [N*DW-1:0]   s_nmi_rdata;
  logic [N-1:0]      s_nmi_ready;
  logic              m_nmi_valid, m_nmi_instr;
  logic [AW-1:0]     m_nmi_addr;
  logic [DW-1:0]     m_nmi_wdata;
  logic [SW-1:0]     m_nmi_wstrb;
`ifdef NMI_ARBITER_TIMEOUT_EN
  logic              timeout_err;
`endif

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign s_nmi_addr[i*AW +: AW]  = a_addr[i];
    assign s_nmi_wdata[i*DW +: DW] = a_wdata[i];
    assign s_nmi_wstrb[i*SW +: SW] = a_wstrb[i];
  end

  nmi_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WSTRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_nmi_valid(v), .s_nmi_instr(ins), .s_nmi_ready(s_nmi_ready),
    .s_nmi_addr(s_nmi_addr), .s_nmi_wdata(s_nmi_wdata), .s_nmi_wstrb(s_nmi_wstrb),
    .s_nmi_rdata(s_nmi_rdata),
    .m_nmi_valid(m_nmi_valid), .m_nmi_instr(m_nmi_instr), .m_nmi_ready(mr),
    .m_nmi_addr(m_nmi_addr), .m_nmi_wdata(m_nmi_wdata), .m_nmi_wstrb(m_nmi_wstrb),
    .m_nmi_rdata(mrd)
`ifdef NMI_ARBITER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: owner of the bus (-1 = none), priority pointer, stall count.
  int           owner = -1;
  int           ptr   = 0;
  int           stall = 0;
  logic [N-1:0] exp_ready = '0;
  int           order_q[$];

  always @(negedge clk) begin
    logic [N-1:0] er;
    logic         ev, ab;
    int           src, best, db, di;
    if (!resetn) begin
      owner = -1; ptr = 0; stall = 0; exp_ready = '0;
      chk("rst_m_valid", {63'd0, m_nmi_valid}, 64'd0);
      chk("rst_ready", {61'd0, s_nmi_ready}, 64'd0);
    end else begin
      er = '0; ev = 1'b0; ab = 1'b0;
      if (owner >= 0) begin
`ifdef NMI_ARBITER_TIMEOUT_EN
        ab = (stall == TO);
`endif
        ev = v[owner] && !ab;
        er[owner] = ab || (ev && mr);
      end
      src = (owner >= 0) ? owner : 0;
      chk("m_valid", {63'd0, m_nmi_valid}, {63'd0, ev});
      chk("s_ready", {61'd0, s_nmi_ready}, {61'd0, er});
      chk("m_addr", {32'd0, m_nmi_addr}, {32'd0, a_addr[src]});
      chk("m_wdata", {32'd0, m_nmi_wdata}, {32'd0, a_wdata[src]});
      chk("m_wstrb", {60'd0, m_nmi_wstrb}, {60'd0, a_wstrb[src]});
      chk("m_instr", {63'd0, m_nmi_instr}, {63'd0, ins[src]});
      for (int i = 0; i < N; i++)
        if (er[i]) chk("s_rdata", {32'd0, s_nmi_rdata[i*DW +: DW]}, {32'd0, ab ? 32'hDEADDEAD : mrd});
`ifdef NMI_ARBITER_TIMEOUT_EN
      chk("timeout_err", {63'd0, timeout_err}, {63'd0, ab});
`endif
      exp_ready = er;
      if (er != '0) order_q.push_back(owner);
      if (owner >= 0) begin
        if (er[owner]) begin
          ptr = (owner + 1) % N;
          owner = -1;
        end else if (!v[owner]) begin
          owner = -1;
        end else if (!mr) begin
          stall++;
        end
      end else begin
        // Winner: pending master with the smallest rotational distance from ptr.
        best = -1;
        for (int i = 0; i < N; i++) begin
          if (v[i]) begin
            di = (i - ptr + N) % N;
            db = (best < 0) ? N : (best - ptr + N) % N;
            if (di < db) best = i;
          end
        end
        if (best >= 0) begin
          owner = best;
          stall = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic new_req(input int i);
    v[i]       = 1'b1;
    a_addr[i]  = $urandom;
    a_wdata[i] = $urandom;
    a_wstrb[i] = SW'($urandom_range(0, 15));
    ins[i]     = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_phase(input int cycles, input int ready_pct);
    for (int c = 0; c < cycles; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (v[i] && exp_ready[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else v[i] = 1'b0;
        end else if (v[i]) begin
          if ($urandom_range(0, 63) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
      mr  = ($urandom_range(0, 99) < ready_pct);
      mrd = $urandom;
    end
  endtask

  initial begin
    resetn = 1'b0;
    v = '0; ins = '0; mr = 1'b0; mrd = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0; a_wdata[i] = '0; a_wstrb[i] = '0;
    end
    #3;
    chk("reset_m_valid", {63'd0, m_nmi_valid}, 64'd0);
    do_reset();

    // Single zero-wait read from master 0.
    a_addr[0] = 32'h1111_0010; v[0] = 1'b1; mr = 1'b1; mrd = 32'hCAFE_F00D;
    #2 chk("A_idle_valid", {63'd0, m_nmi_valid}, 64'd0);
    step();
    #2;
    chk("A_m_valid", {63'd0, m_nmi_valid}, 64'd1);
    chk("A_ready", {61'd0, s_nmi_ready}, 64'd1);
    chk("A_rdata0", {32'd0, s_nmi_rdata[31:0]}, 64'hCAFE_F00D);
    chk("A_addr", {32'd0, m_nmi_addr}, 64'h1111_0010);
    step();
    v[0] = 1'b0;
    #2 chk("A_back_idle", {63'd0, m_nmi_valid}, 64'd0);

    // Three masters requesting continuously: strict rotation.
    do_reset();
    order_q.delete();
    v = '1; mr = 1'b1;
    repeat (12) step();
    v = '0;
    step();
    chk("B_pulses", 64'(order_q.size() >= 6), 64'd1);
    for (int k = 0; k < 6 && k < order_q.size(); k++)
      chk("B_order", 64'(order_q[k]), 64'(k % 3));

    // Master 1 write with three wait states.
    a_addr[1] = 32'h2222_1004; a_wdata[1] = 32'h1234_5678; a_wstrb[1] = 4'hF;
    v[1] = 1'b1; mr = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      mr = (k == 3);
      #2;
      chk("C_valid", {63'd0, m_nmi_valid}, 64'd1);
      chk("C_addr", {32'd0, m_nmi_addr}, 64'h2222_1004);
      chk("C_wdata", {32'd0, m_nmi_wdata}, 64'h1234_5678);
      chk("C_wstrb", {60'd0, m_nmi_wstrb}, 64'hF);
      chk("C_ready", {61'd0, s_nmi_ready}, (k == 3) ? 64'd2 : 64'd0);
      step();
    end
    v[1] = 1'b0; mr = 1'b0;
    step();

    // Withdrawal keeps priority with master 0.
    do_reset();
    a_addr[0] = 32'h0000_00A0; a_addr[1] = 32'h0000_00B0;
    v[0] = 1'b1; mr = 1'b0;
    step();
    #2 chk("D_busy", {63'd0, m_nmi_valid}, 64'd1);
    step();
    v[0] = 1'b0;
    #2;
    chk("D_drop_valid", {63'd0, m_nmi_valid}, 64'd0);
    chk("D_drop_ready", {61'd0, s_nmi_ready}, 64'd0);
    step();
    v[0] = 1'b1; v[1] = 1'b1;
    step();
    #2;
    chk("D_regrant_valid", {63'd0, m_nmi_valid}, 64'd1);
    chk("D_regrant_addr", {32'd0, m_nmi_addr}, 64'h0000_00A0);
    mr = 1'b1;
    step();
    v[0] = 1'b0;
    step();
    step();
    v = '0; mr = 1'b0;
    step();

    // Asynchronous reset during a wait state.
    a_addr[0] = 32'h0000_0C00; a_addr[1] = 32'h0000_0C01; a_addr[2] = 32'h0000_0C02;
    v[2] = 1'b1; mr = 1'b0;
    step();
    step();
    #2 chk("E_busy", {63'd0, m_nmi_valid}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("E_rst_valid", {63'd0, m_nmi_valid}, 64'd0);
    chk("E_rst_ready", {61'd0, s_nmi_ready}, 64'd0);
    step();
    v = '0; resetn = 1'b1;
    #2 chk("E_idle_addr", {32'd0, m_nmi_addr}, 64'h0000_0C00);
    v[1] = 1'b1; v[2] = 1'b1;
    step();
    #2;
    chk("E_grant_valid", {63'd0, m_nmi_valid}, 64'd1);
    chk("E_grant_addr", {32'd0, m_nmi_addr}, 64'h0000_0C01);
    mr = 1'b1;
    step();
    v[1] = 1'b0;
    step();
    v = '0; mr = 1'b0;
    step();
    step();

`ifdef NMI_ARBITER_TIMEOUT_EN
    // Stalled slave: valid for exactly TO cycles, then abort.
    v[0] = 1'b1; mr = 1'b0; mrd = 32'h0;
    step();
    for (int k = 0; k < TO; k++) begin
      #2 chk("F_valid", {63'd0, m_nmi_valid}, 64'd1);
      step();
    end
    #2;
    chk("F_timeout", {63'd0, timeout_err}, 64'd1);
    chk("F_ready", {61'd0, s_nmi_ready}, 64'd1);
    chk("F_rdata", {32'd0, s_nmi_rdata[31:0]}, 64'hDEAD_DEAD);
    chk("F_valid_low", {63'd0, m_nmi_valid}, 64'd0);
    step();
    v = '0;
    step();
`endif

    rand_phase(2000, 50);
    rand_phase(1500, 4);
    v = '0; mr = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmi_arbiter.md
# nmi_arbiter

Round-robin N-to-1 arbiter for the NMI (native memory interface) bus. It sits directly upstream of the NMI address-decode interconnect and merges several NMI masters onto its single slave port, for example a CPU instruction port, a CPU data port and a debug/DMA master. Each transaction is locked to one master from grant until completion. Fairness comes from a rotating priority pointer.

## Interface
Parameters:
- N_MASTERS, 2 — number of upstream masters; must be ≥ 2.
- ADDR_WIDTH, 32 — address width.
- DATA_WIDTH, 32 — data width; must be a multiple of 16.
- WSTRB_WIDTH, (DATA_WIDTH-1)/8+1 — byte-strobe width.
- TIMEOUT_CYCLES, 16 — stall limit before abort. Used only with the timeout macro; must be ≥ 1.

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- clk  in  1  — clock; all state updates on the rising edge.
- resetn  in  1  — asynchronous, active-low reset.
- s_nmi_valid  in  N_MASTERS  — per-master request.
- s_nmi_instr  in  N_MASTERS  — per-master instruction-fetch flag.
- s_nmi_ready  out  N_MASTERS  — per-master completion strobe.
- s_nmi_addr  in  N_MASTERS*ADDR_WIDTH  — packed addresses; master i occupies slice i.
- s_nmi_wdata  in  N_MASTERS*DATA_WIDTH  — packed write data.
- s_nmi_wstrb  in  N_MASTERS*WSTRB_WIDTH  — packed strobes; 0 means read.
- s_nmi_rdata  out  N_MASTERS*DATA_WIDTH  — packed read data.
- m_nmi_valid  out  1  — request to the interconnect.
- m_nmi_instr  out  1  — forwarded instruction flag.
- m_nmi_ready  in  1  — completion from the interconnect.
- m_nmi_addr  out  ADDR_WIDTH  — forwarded address.
- m_nmi_wdata  out  DATA_WIDTH  — forwarded write data.
- m_nmi_wstrb  out  WSTRB_WIDTH  — forwarded strobes.
- m_nmi_rdata  in  DATA_WIDTH  — read data from the interconnect.
- timeout_err  out  1  — one-cycle abort pulse. Present only with NMI_ARBITER_TIMEOUT_EN.

## Operation
- State registers: state {IDLE, BUSY}, grant (clog2(N_MASTERS) bits), rr_ptr (same width). Reset values: IDLE, 0, 0.
- Reset values of outputs while in IDLE or reset: m_nmi_valid=0, all s_nmi_ready=0, timeout_err=0. m_nmi_addr, m_nmi_wdata, m_nmi_wstrb and m_nmi_instr drive slice 0 when not BUSY.
- IDLE:
  - Scan masters rr_ptr, rr_ptr+1, … (mod N_MASTERS) and pick the first with s_nmi_valid=1.
  - Register that index into grant and go to BUSY.
  - If no master is valid, stay in IDLE.
- BUSY, forwarding:
  - m_nmi_valid = s_nmi_valid[grant].
  - m_nmi_addr, m_nmi_wdata, m_nmi_wstrb and m_nmi_instr are combinational muxes of the grant slice.
- BUSY, ready and read data:
  - s_nmi_ready[grant] = m_nmi_ready & m_nmi_valid. All other ready bits are 0.
  - m_nmi_rdata is broadcast to every s_nmi_rdata slice. A slice is meaningful only when its ready bit is 1.
- BUSY, completion: when m_nmi_valid & m_nmi_ready, set rr_ptr = grant+1 (N_MASTERS-1 wraps to 0) and return to IDLE.
- BUSY, withdrawal: if s_nmi_valid[grant] drops without completion (protocol violation), return to IDLE with rr_ptr unchanged and no ready pulse.
- Masters must hold valid and all request fields stable until they see ready.
- A master re-requesting immediately after completion loses priority to any other pending master.

## Timing
- Arbitration latency: request first sampled in IDLE in cycle t; m_nmi_valid high in cycle t+1.
- With a zero-wait slave, s_nmi_ready pulses in t+1 and the state is IDLE again in t+2.
- Peak throughput: one transaction per 2 cycles. A back-to-back request from the same master reaches m_nmi_valid at t+3.
- Wait states: each cycle with m_nmi_ready=0 extends BUSY by one cycle.
- Asynchronous reset mid-transaction: state returns to IDLE immediately, m_nmi_valid drops combinationally, and the in-flight transaction is dropped with no ready pulse.

## Configuration
- NMI_ARBITER_TIMEOUT_EN defined:
  - A stall counter of clog2(TIMEOUT_CYCLES+1) bits clears on entry to BUSY and increments on each BUSY cycle with m_nmi_ready=0.
  - When the counter equals TIMEOUT_CYCLES, that cycle is the abort cycle:
    - m_nmi_valid is forced to 0.
    - s_nmi_ready[grant]=1.
    - every rdata slice carries {DATA_WIDTH/16{16'hDEAD}}.
    - timeout_err=1.
    - rr_ptr advances as on a normal completion, and the state returns to IDLE.
  - The slave therefore sees valid for exactly TIMEOUT_CYCLES cycles.
- NMI_ARBITER_TIMEOUT_EN undefined: no counter and no timeout_err port; a stalled slave blocks the bus indefinitely.

## Test plan
- Single master 0 read of 0x1111_0010, zero-wait slave returning 0xCAFE_F00D → m_nmi_valid in the cycle after the request; s_nmi_ready[0] and rdata slice 0 = 0xCAFE_F00D in that same cycle.
- N_MASTERS=3, all three valid continuously after reset → grant order 0,1,2,0,1,2; no two ready bits high in the same cycle.
- Master 1 write (addr 0x2222_1004, wdata 0x1234_5678, wstrb 0xF) with 3 wait states → m_* fields stable for 4 cycles; s_nmi_ready[1] pulses once in the 4th cycle.
- Master 0 drops valid while BUSY → return to IDLE, no ready pulse, rr_ptr unchanged, so master 0 wins again on re-request.
- Reset asserted mid-wait-state → m_nmi_valid=0 immediately; after release, grant=0, rr_ptr=0, state IDLE.
- With the macro defined, TIMEOUT_CYCLES=16 and m_nmi_ready held at 0 → m_nmi_valid high for 16 cycles; in the 17th cycle, timeout_err=1, s_nmi_ready[grant]=1, rdata=0xDEADDEAD.
